spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_pkg.sv | 12 +
 rtl/spi_slave_sync_ff.sv | 28 ++
 rtl/spi_slave.sv | 179 +++++++++++++++++
 tb/tb_spi_slave.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI slave.
package spi_slave_pkg;

  localparam int         DATA_W_DEF = 8;
  localparam logic [7:0] DEFAULT_TX = 8'h00;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

endpackage

// File: rtl/spi_slave_sync_ff.sv
// N-stage synchronizer with a selectable reset value.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stages;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= {STAGES{RESET_VAL}};
    end else begin
      stages[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign q = stages[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode 0 slave, MSB first, oversampled in the system clock domain.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_err
);

  localparam int                CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] DEF_TX = DATA_W'(DEFAULT_TX);

  state_t state, next_state;

  logic sclk_s, cs_s, mosi_s, warm;
  logic sclk_d, cs_d, armed;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic start_frame, end_frame, bit_rise, bit_fall, wrap, load;

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift, tx_shift, hold_data;
  logic              hold_full, rx_done;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(cs), .q(cs_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s)
  );

  // Goes high once the synchronizers hold real pin values rather than reset values
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_warm (
    .clk(clk), .rst_n(rst_n), .d(1'b1), .q(warm)
  );

  // Edge-detect register; armed only after cs has genuinely been seen high, so a
  // reset released with cs already low cannot fake a frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
      armed  <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
      armed  <= armed | (warm & cs_s);
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and frame strobes; a cs rise masks any sclk edge in the same cycle
  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    bit_rise    = 1'b0;
    bit_fall    = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall && armed) begin
          next_state  = ACTIVE;
          start_frame = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          next_state = IDLE;
          end_frame  = 1'b1;
        end else begin
          bit_rise = sclk_rise;
          bit_fall = sclk_fall;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign wrap     = bit_rise && (bit_cnt == LAST);
  assign load     = start_frame | wrap;
  assign miso_oe  = (state == ACTIVE);
  assign tx_ready = ~hold_full;

  // Holding register: a load empties it, otherwise it accepts one byte when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (load && hold_full) begin
      hold_full <= 1'b0;
    end else if (tx_valid && !hold_full) begin
      hold_data <= tx_data;
      hold_full <= 1'b1;
    end
  end

  // Transmit shifter: loads at frame start and byte wrap, shifts on sclk fall mid-byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift    <= '0;
      tx_underrun <= 1'b0;
      miso        <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      miso        <= tx_shift[DATA_W-1];
      if (load) begin
        tx_shift    <= hold_full ? hold_data : DEF_TX;
        tx_underrun <= ~hold_full;
      end else if (bit_fall && (bit_cnt != '0)) begin
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Bit counter, cleared at frame start and wrapping every DATA_W sclk rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (start_frame) begin
      bit_cnt <= '0;
    end else if (bit_rise) begin
      bit_cnt <= wrap ? '0 : bit_cnt + 1'b1;
    end
  end

  // Receive shifter; the completed byte is published together with its valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift  <= '0;
      rx_done   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= wrap;
      rx_valid  <= rx_done;
      frame_err <= end_frame && (bit_cnt != '0);
      if (bit_rise) begin
        rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
      end
      if (rx_done) begin
        rx_data <= rx_shift;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed testbench for spi_slave (DATA_W=8, SYNC_STAGES=2, sclk = clk/8).
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, tx_underrun, frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int last_latency = -1;
  int rx_count = 0;
  int underrun_count = 0;
  int ferr_count = 0;
  logic [7:0] rx_log[$];

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Free-running count of rising clock edges
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge away from DUT updates
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_count++;
      rx_log.push_back(rx_data);
      last_latency = cyc - rise_cyc;
    end
    if (tx_underrun) underrun_count++;
    if (frame_err) ferr_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] logAt(input int idx);
    if (idx < rx_log.size()) return {24'h0, rx_log[idx]};
    return 32'hDEAD;
  endfunction

  task automatic loadTx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    waitCycles(1);
    tx_valid = 1'b0;
  endtask

  // Master side of one byte: drive mosi in the low phase, sample miso at each rise
  task automatic applyStimulus(input logic [7:0] mosi_byte, input int nbits, output logic [7:0] miso_byte);
    miso_byte = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mosi_byte[7-i];
      waitCycles(4);
      miso_byte = {miso_byte[6:0], miso};
      sclk = 1'b1;
      rise_cyc = cyc;
      waitCycles(4);
      sclk = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] mb1, mb2;
    int rx0, ur0, fe0;

    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(4);

    checkOutput("rst_miso", miso, 0);
    checkOutput("rst_miso_oe", miso_oe, 0);
    checkOutput("rst_rx_data", rx_data, 0);
    checkOutput("rst_rx_valid", rx_valid, 0);
    checkOutput("rst_tx_ready", tx_ready, 1);
    checkOutput("rst_underrun", tx_underrun, 0);
    checkOutput("rst_frame_err", frame_err, 0);

    // Single byte: tx 3C, rx A5
    loadTx(8'h3C);
    checkOutput("t1_ready_after_capture", tx_ready, 0);
    rx0 = rx_count; ur0 = underrun_count; fe0 = ferr_count;
    cs = 1'b0;
    waitCycles(4);
    checkOutput("t1_oe_active", miso_oe, 1);
    checkOutput("t1_no_underrun_at_start", underrun_count - ur0, 0);
    applyStimulus(8'hA5, 8, mb1);
    waitCycles(4);
    cs = 1'b1;
    waitCycles(6);
    checkOutput("t1_miso_byte", mb1, 8'h3C);
    checkOutput("t1_rx_data", rx_data, 8'hA5);
    checkOutput("t1_rx_pulses", rx_count - rx0, 1);
    checkOutput("t1_rx_latency", last_latency, 4);
    checkOutput("t1_underrun_wrap", underrun_count - ur0, 1);
    checkOutput("t1_no_frame_err", ferr_count - fe0, 0);
    checkOutput("t1_oe_idle", miso_oe, 0);
    checkOutput("t1_ready_idle", tx_ready, 1);

    // Back-to-back bytes; 22 enters the holding register as soon as 11 is loaded
    loadTx(8'h11);
    rx0 = rx_count; ur0 = underrun_count;
    cs = 1'b0;
    waitCycles(4);
    checkOutput("t2_ready_after_load", tx_ready, 1);
    loadTx(8'h22);
    applyStimulus(8'hF0, 8, mb1);
    applyStimulus(8'h0F, 8, mb2);
    waitCycles(4);
    cs = 1'b1;
    waitCycles(6);
    checkOutput("t2_miso_first", mb1, 8'h11);
    checkOutput("t2_miso_second", mb2, 8'h22);
    checkOutput("t2_rx_pulses", rx_count - rx0, 2);
    checkOutput("t2_rx_first", logAt(rx0), 8'hF0);
    checkOutput("t2_rx_second", logAt(rx0 + 1), 8'h0F);
    checkOutput("t2_underrun_final_wrap", underrun_count - ur0, 1);

    // Underrun at frame start
    ur0 = underrun_count;
    cs = 1'b0;
    waitCycles(4);
    checkOutput("t3_underrun_at_start", underrun_count - ur0, 1);
    applyStimulus(8'h55, 8, mb1);
    waitCycles(4);
    cs = 1'b1;
    waitCycles(6);
    checkOutput("t3_miso_default", mb1, 8'h00);
    checkOutput("t3_rx_data", rx_data, 8'h55);

    // cs rises after 5 bits
    rx0 = rx_count; fe0 = ferr_count;
    cs = 1'b0;
    waitCycles(4);
    applyStimulus(8'hB4, 5, mb1);
    waitCycles(4);
    cs = 1'b1;
    waitCycles(6);
    checkOutput("t4_frame_err", ferr_count - fe0, 1);
    checkOutput("t4_no_rx", rx_count - rx0, 0);
    checkOutput("t4_rx_kept", rx_data, 8'h55);
    checkOutput("t4_oe_low", miso_oe, 0);

    // Reset mid-frame, released with cs low
    cs = 1'b0;
    waitCycles(4);
    applyStimulus(8'hE0, 3, mb1);
    rx0 = rx_count; ur0 = underrun_count; fe0 = ferr_count;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_oe", miso_oe, 0);
    checkOutput("t5_rst_rx_data", rx_data, 0);
    checkOutput("t5_rst_tx_ready", tx_ready, 1);
    checkOutput("t5_rst_miso", miso, 0);
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(6);
    checkOutput("t5_no_frame_after_rst", miso_oe, 0);
    applyStimulus(8'hC3, 8, mb1);
    waitCycles(6);
    checkOutput("t5_stale_cs_no_rx", rx_count - rx0, 0);
    checkOutput("t5_stale_cs_no_underrun", underrun_count - ur0, 0);
    checkOutput("t5_stale_cs_oe", miso_oe, 0);
    cs = 1'b1;
    waitCycles(6);
    checkOutput("t5_no_frame_err", ferr_count - fe0, 0);
    cs = 1'b0;
    waitCycles(4);
    checkOutput("t5_fresh_frame_oe", miso_oe, 1);
    applyStimulus(8'hC3, 8, mb1);
    waitCycles(4);
    cs = 1'b1;
    waitCycles(6);
    checkOutput("t5_rx_data", rx_data, 8'hC3);
    checkOutput("t5_rx_pulses", rx_count - rx0, 1);
    checkOutput("t5_rx_latency", last_latency, 4);

    // Holding register full: 88 must wait until 77 is consumed
    tx_data  = 8'h77;
    tx_valid = 1'b1;
    waitCycles(1);
    tx_data = 8'h88;
    waitCycles(3);
    checkOutput("t6_ready_full", tx_ready, 0);
    cs = 1'b0;
    waitCycles(4);
    tx_valid = 1'b0;
    checkOutput("t6_ready_recaptured", tx_ready, 0);
    applyStimulus(8'h9A, 8, mb1);
    applyStimulus(8'h6B, 8, mb2);
    waitCycles(4);
    cs = 1'b1;
    waitCycles(6);
    checkOutput("t6_miso_first", mb1, 8'h77);
    checkOutput("t6_miso_second", mb2, 8'h88);
    checkOutput("t6_ready_end", tx_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
